reg_file_sync: RTL and testbench
================================

// Module: reg_file_sync
// PURPOSE
//   Parametrised, clocked general-purpose register file for the MIPS datapath.
//   2 combinational read ports, 1 synchronous write port, optional hardwired-zero r0
//   and optional write-to-read bypass. A built-in clear sequencer zeroes every entry
//   after reset or on request, and reports progress on oBusy.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   register address width
//   NUM_REGS  32  implemented entries, 2 <= NUM_REGS <= 2**ADDR_W
//   ZERO_REG  1   1: r0 always reads 0 and writes to r0 are discarded
//   BYPASS    1   1: same-cycle write data is forwarded to a matching read port
// PORTS
//   iClk     in   1       clock; all state changes on the rising edge
//   iReset   in   1       synchronous, active-high reset
//   iClear   in   1       1-cycle request to re-zero all entries
//   iReg1    in   ADDR_W  read port 1 address
//   iReg2    in   ADDR_W  read port 2 address
//   iWrReg3  in   ADDR_W  write address
//   iRegWr   in   1       write enable
//   iWrData  in   DATA_W  write data
//   oReg1    out  DATA_W  read port 1 data (combinational)
//   oReg2    out  DATA_W  read port 2 data (combinational)
//   oBusy    out  1       1 while the clear sequencer runs (Moore, decoded from state)
// BEHAVIOUR
//   States: INIT (clearing), READY. Clear pointer ptr is ADDR_W bits wide.
//   Reset: edge with iReset=1 -> state=INIT, ptr=0. Reset beats every other input.
//     Array contents are not reset directly; the sequencer clears them.
//   INIT: each edge writes 0 to entry ptr and increments ptr. On the edge that clears
//     entry NUM_REGS-1, state=READY. oBusy is high for exactly NUM_REGS cycles after
//     iReset is released.
//   INIT: iRegWr is ignored (write dropped) and iClear is ignored (no restart).
//     oReg1 and oReg2 are forced to 0.
//   READY: a write occurs on the edge when iRegWr=1, iClear=0, iWrReg3 < NUM_REGS and
//     !(ZERO_REG && iWrReg3==0). Latency: visible on the reads in the next cycle.
//   READY + iClear=1: state=INIT, ptr=0. A write in the same cycle is dropped.
//   Read mux, per port, in priority order:
//     a) state==INIT -> 0
//     b) addr >= NUM_REGS -> 0
//     c) ZERO_REG && addr==0 -> 0
//     d) BYPASS && write qualifies this cycle && iWrReg3==addr -> iWrData
//     e) otherwise general_regs[addr]
//   With BYPASS=0, a read of the address being written returns the old value
//     until the edge.
//   Both ports may read the same address in the same cycle. Reads never change state.
//   Reset mid-INIT restarts the pointer at 0; the full NUM_REGS-cycle clear is repeated.
//   No write-collision case exists: there is a single write port.
// TESTING
//   T1 Release reset -> oBusy=1 for exactly 32 cycles then 0. Reads are 0 throughout.
//      Write r3=0xA5A5A5A5 during busy -> r3 reads 0 after busy.
//   T2 READY: write r5=0xDEADBEEF with iReg1=5 the same cycle -> oReg1=0xDEADBEEF
//      (BYPASS=1) or 0 (BYPASS=0). Next cycle oReg1=0xDEADBEEF in both builds.
//   T3 Write r0=0x12345678 -> oReg1(r0)=0 (ZERO_REG=1).
//      With ZERO_REG=0, 0x12345678 is read next cycle.
//   T4 Write r7=1, r8=2. Set iReg1=iReg2=7 while writing r9=3 -> both ports=1.
//      Then iReg1=8, iReg2=9 -> 2 and 3.
//   T5 Registers loaded, then iClear=1 with iRegWr=1 on r4=0xFF -> write dropped.
//      oBusy=1 for 32 cycles, then all entries read 0.
//   T6 Assert iReset when ptr=10 in INIT -> after release oBusy=1 for 32 cycles.
//      NUM_REGS=24, ADDR_W=5: read/write address 30 -> reads 0, no state change.

Source files
------------

// File: rtl/reg_file_sync.sv
// General-purpose register file: two combinational read ports, one synchronous
// write port, optional hardwired r0 and write-to-read bypass, plus a clear sequencer.
module reg_file_sync #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iClear,
    input  logic [ADDR_W-1:0] iReg1,
    input  logic [ADDR_W-1:0] iReg2,
    input  logic [ADDR_W-1:0] iWrReg3,
    input  logic              iRegWr,
    input  logic [DATA_W-1:0] iWrData,
    output logic [DATA_W-1:0] oReg1,
    output logic [DATA_W-1:0] oReg2,
    output logic              oBusy
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } stateType;

    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    stateType          state;
    stateType          stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;
    logic              clearEn;
    logic              wrQual;
    logic [ADDR_W-1:0] rdIdx1;
    logic [ADDR_W-1:0] rdIdx2;

    logic [DATA_W-1:0] generalRegs [NUM_REGS];

    // One extra bit so NUM_REGS == 2**ADDR_W compares correctly.
    function automatic logic inRange(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < NUM_REGS_W;
    endfunction

    function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    function automatic logic [DATA_W-1:0] readMux(
        input logic              busy,
        input logic              wrHit,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wrData,
        input logic [DATA_W-1:0] stored
    );
        if (busy)
            return '0;
        else if (!inRange(addr))
            return '0;
        else if (isZeroReg(addr))
            return '0;
        else if ((BYPASS != 0) && wrHit)
            return wrData;
        else
            return stored;
    endfunction

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        oBusy     = 1'b0;
        clearEn   = 1'b0;
        case (state)
            INIT: begin
                oBusy   = 1'b1;
                clearEn = 1'b1;
                if (ptr == LAST_PTR) begin
                    stateNext = READY;
                    ptrNext   = '0;
                end else begin
                    ptrNext = ptr + 1'b1;
                end
            end
            READY: begin
                if (iClear) begin
                    stateNext = INIT;
                    ptrNext   = '0;
                end
            end
        endcase
    end

    // A write lands only when the file is idle and nothing higher-priority claims the edge.
    assign wrQual = (state == READY) && !iReset && iRegWr && !iClear &&
                    inRange(iWrReg3) && !isZeroReg(iWrReg3);

    always_ff @(posedge iClk) begin
        if (clearEn && !iReset)
            generalRegs[ptr] <= '0;
        else if (wrQual)
            generalRegs[iWrReg3] <= iWrData;
    end

    // Out-of-range addresses are masked later; keep the array index legal.
    assign rdIdx1 = inRange(iReg1) ? iReg1 : '0;
    assign rdIdx2 = inRange(iReg2) ? iReg2 : '0;

    always_comb begin
        oReg1 = readMux(oBusy, wrQual && (iWrReg3 == iReg1), iReg1, iWrData, generalRegs[rdIdx1]);
        oReg2 = readMux(oBusy, wrQual && (iWrReg3 == iReg2), iReg2, iWrData, generalRegs[rdIdx2]);
    end

endmodule

// File: tb/tb_reg_file_sync.sv
// Bench for reg_file_sync: two builds (32/r0/bypass and 24/no-r0/no-bypass) share one
// stimulus stream; expected reads are queued per cycle and checked by a monitor.
module tb_reg_file_sync;

    logic        clk = 1'b0;
    logic        rst, clr, we;
    logic [4:0]  r1, r2, wa;
    logic [31:0] wd;
    logic [31:0] a1, a2, b1, b2;
    logic        aBusy, bBusy;

    always #5 clk = ~clk;

    reg_file_sync #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dutA (
        .iClk(clk), .iReset(rst), .iClear(clr), .iReg1(r1), .iReg2(r2), .iWrReg3(wa),
        .iRegWr(we), .iWrData(wd), .oReg1(a1), .oReg2(a2), .oBusy(aBusy));

    reg_file_sync #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) dutB (
        .iClk(clk), .iReset(rst), .iClear(clr), .iReg1(r1), .iReg2(r2), .iWrReg3(wa),
        .iRegWr(we), .iWrData(wd), .oReg1(b1), .oReg2(b2), .oBusy(bBusy));

    // Reference model: per-build register contents and cycles of clearing still to run.
    int          nRegs   [2] = '{32, 24};
    bit          zeroReg [2] = '{1'b1, 1'b0};
    bit          bypass  [2] = '{1'b1, 1'b0};
    logic [31:0] mRegs   [2][32];
    int          busyLeft[2] = '{0, 0};

    typedef struct {
        string       tag;
        logic [31:0] a1, a2, b1, b2;
        logic        aBusy, bBusy;
    } expT;

    expT q[$];
    int  nChecks = 0;
    int  nFails  = 0;

    function automatic bit qual(int c);
        return !rst && busyLeft[c] == 0 && we && !clr && int'(wa) < nRegs[c] &&
               !(zeroReg[c] && wa == 5'd0);
    endfunction

    function automatic logic [31:0] mRead(int c, logic [4:0] addr);
        if (busyLeft[c] > 0) return 32'd0;
        if (int'(addr) >= nRegs[c]) return 32'd0;
        if (zeroReg[c] && addr == 5'd0) return 32'd0;
        if (bypass[c] && qual(c) && wa == addr) return wd;
        return mRegs[c][addr];
    endfunction

    task automatic mEdge(int c);
        if (rst || (busyLeft[c] == 0 && clr)) begin
            busyLeft[c] = nRegs[c];
            for (int i = 0; i < 32; i++) mRegs[c][i] = 32'd0;
        end else if (busyLeft[c] > 0) begin
            busyLeft[c]--;
        end else if (qual(c)) begin
            mRegs[c][wa] = wd;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge; optionally queue the expectation.
    task automatic cyc(bit pr, bit r, bit c, logic [4:0] x1, logic [4:0] x2,
                       logic [4:0] w, bit e, logic [31:0] d, string tag);
        expT ex;
        rst = r; clr = c; r1 = x1; r2 = x2; wa = w; we = e; wd = d;
        if (pr) begin
            ex.tag   = tag;
            ex.a1    = mRead(0, x1);
            ex.a2    = mRead(0, x2);
            ex.b1    = mRead(1, x1);
            ex.b2    = mRead(1, x2);
            ex.aBusy = busyLeft[0] > 0;
            ex.bBusy = busyLeft[1] > 0;
            q.push_back(ex);
        end
        mEdge(0);
        mEdge(1);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(logic [4:0] x1, logic [4:0] x2, string tag);
        cyc(1'b1, 1'b0, 1'b0, x1, x2, 5'd0, 1'b0, 32'd0, tag);
    endtask

    task automatic wr(logic [4:0] w, logic [31:0] d, logic [4:0] x1, logic [4:0] x2, string tag);
        cyc(1'b1, 1'b0, 1'b0, x1, x2, w, 1'b1, d, tag);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            expT e;
            e = q.pop_front();
            chk({e.tag, ".A.busy"}, {31'd0, aBusy}, {31'd0, e.aBusy});
            chk({e.tag, ".B.busy"}, {31'd0, bBusy}, {31'd0, e.bBusy});
            chk({e.tag, ".A.reg1"}, a1, e.a1);
            chk({e.tag, ".A.reg2"}, a2, e.a2);
            chk({e.tag, ".B.reg1"}, b1, e.b1);
            chk({e.tag, ".B.reg2"}, b2, e.b2);
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; r1 = '0; r2 = '0; wa = '0; wd = '0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, "rst0");
        cyc(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd0, 1'b0, 32'd0, "rst");

        // Busy window: writes and clears are ignored, reads forced to zero.
        for (int i = 0; i < 36; i++) begin
            if (i == 5)
                wr(5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, "t1wr");
            else if (i == 9)
                cyc(1'b1, 1'b0, 1'b1, 5'd3, 5'd2, 5'd0, 1'b0, 32'd0, "t1clr");
            else
                rd(5'(i), 5'd3, "t1busy");
        end
        rd(5'd3, 5'd3, "t1r3");

        wr(5'd5, 32'hDEADBEEF, 5'd5, 5'd6, "t2byp");
        rd(5'd5, 5'd5, "t2next");

        wr(5'd0, 32'h12345678, 5'd0, 5'd0, "t3wr");
        rd(5'd0, 5'd0, "t3rd");

        wr(5'd7, 32'd1, 5'd7, 5'd8, "t4a");
        wr(5'd8, 32'd2, 5'd7, 5'd8, "t4b");
        wr(5'd9, 32'd3, 5'd7, 5'd7, "t4same");
        rd(5'd8, 5'd9, "t4rd");

        wr(5'd4, 32'h0000_1234, 5'd4, 5'd7, "t5ld");
        cyc(1'b1, 1'b0, 1'b1, 5'd4, 5'd7, 5'd4, 1'b1, 32'h000000FF, "t5clr");
        for (int i = 0; i < 34; i++) rd(5'd4, 5'(i), "t5busy");
        for (int i = 0; i < 32; i += 2) rd(5'(i), 5'(i + 1), "t5zero");

        cyc(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'd0, "t6rst");
        for (int i = 0; i < 10; i++) rd(5'd1, 5'd2, "t6init");
        cyc(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'd0, "t6rst2");
        for (int i = 0; i < 34; i++) rd(5'd30, 5'd0, "t6busy");
        wr(5'd30, 32'hCAFEF00D, 5'd30, 5'd23, "t6w30");
        wr(5'd23, 32'h0BADBEEF, 5'd30, 5'd23, "t6w23");
        rd(5'd30, 5'd23, "t6rd");

        for (int i = 0; i < 700; i++) begin
            bit r, c, e;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 9) < 7);
            cyc(1'b1, r, c, 5'($urandom), 5'($urandom), 5'($urandom), e, $urandom, "rand");
        end
        rd(5'd1, 5'd2, "last");

        @(negedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
